// File: rtl/fmdll_pkg.sv
//------------------------------------------------------------------------------
// Module  : fmdll_pkg
// Brief   : Shared encodings for the FMDLL hold-control path.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fmdll_pkg;

    localparam logic [1:0] MODE_DIV2  = 2'b00;
    localparam logic [1:0] MODE_DIVM  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int P_MIN = 2;

endpackage

`default_nettype wire

// File: rtl/hld_period_cnt.sv
//------------------------------------------------------------------------------
// Module  : hld_period_cnt
// Brief   : Period counter with shadow period register, load and wrap flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hld_period_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             step,
    input  logic [DIV_W-1:0] p_load,
    output logic             wrap
);
    import fmdll_pkg::*;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period;

    assign wrap = step & (cnt == (period - DIV_W'(1)));

    // load both restarts the count and latches the new period, so a reload at
    // wrap changes the period without losing the wrap itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            period <= DIV_W'(P_MIN);
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt    <= '0;
            period <= p_load;
        end else if (step) begin
            cnt <= wrap ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/hld_ctrl_gen.sv
//------------------------------------------------------------------------------
// Module  : hld_ctrl_gen
// Brief   : Round-robin hold pulse generator with continuous and burst modes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hld_ctrl_gen #(
    parameter  int NCH   = 4,
    parameter  int DIV_W = 8,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_m,
    input  logic             start,
    output logic [NCH-1:0]   ctrl_hld,
    output logic [CH_W-1:0]  ch_idx,
    output logic             frame_tick,
    output logic             busy,
    output logic             done
);
    import fmdll_pkg::*;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [DIV_W-1:0] p_sel;
    logic             mode_cont;
    logic             enter_run;
    logic             enter_burst;
    logic             step;
    logic             wrap;
    logic             last_ch;
    logic             run_reload;
    logic             run_exit;
    logic             last_burst;
    logic             load;
    logic             clr;

    assign mode_cont   = (mode == MODE_DIV2) | (mode == MODE_DIVM);
    assign enter_run   = en & (state == ST_IDLE) & mode_cont;
    assign enter_burst = en & (state == ST_IDLE) & (mode == MODE_BURST) & start;
    assign step        = en & ((state == ST_RUN) | (state == ST_BURST));
    assign last_ch     = (ch_idx == CH_W'(NCH - 1));
    assign run_reload  = (state == ST_RUN) & wrap & mode_cont;
    assign run_exit    = (state == ST_RUN) & wrap & ~mode_cont;
    assign last_burst  = (state == ST_BURST) & wrap & last_ch;
    assign load        = enter_run | enter_burst | run_reload;
    assign clr         = ~en | run_exit;

    always_comb begin
        p_sel = div_m;
        if ((mode == MODE_DIV2) || (div_m < DIV_W'(P_MIN))) begin
            p_sel = DIV_W'(P_MIN);
        end
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enter_run) begin
                        state_nx = ST_RUN;
                    end else if (enter_burst) begin
                        state_nx = ST_BURST;
                    end
                end
                ST_RUN:   if (run_exit) state_nx = ST_IDLE;
                ST_BURST: if (last_burst) state_nx = ST_DONE;
                ST_DONE:  state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    hld_period_cnt #(
        .DIV_W (DIV_W)
    ) u_period_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .load   (load),
        .step   (step),
        .p_load (p_sel),
        .wrap   (wrap)
    );

    // wrap is already gated by en, so a disable on the same edge suppresses the pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ctrl_hld   <= '0;
            ch_idx     <= '0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ST_RUN) | (state_nx == ST_BURST);
            if (!en) begin
                ctrl_hld   <= '0;
                ch_idx     <= '0;
                frame_tick <= 1'b0;
                done       <= 1'b0;
            end else begin
                ctrl_hld   <= wrap ? (NCH'(1) << ch_idx) : '0;
                frame_tick <= wrap & last_ch;
                done       <= last_burst;
                if (enter_run || enter_burst) begin
                    ch_idx <= '0;
                end else if (wrap) begin
                    ch_idx <= last_ch ? '0 : ch_idx + CH_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire
